// File: rtl/ps2_pkg.sv
// Shared types and Set-2 byte constants for the PS/2 scan-code sequencer.
// Event layout is {ext, rel, code}; modifier keys are identified by {ext, code}.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        EXT,
        BRK,
        EXTBRK,
        PAUSE
    } dec_state_t;

    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } key_event_t;

    localparam logic [7:0] PS2_E0         = 8'hE0;
    localparam logic [7:0] PS2_F0         = 8'hF0;
    localparam logic [7:0] PS2_E1         = 8'hE1;
    localparam logic [7:0] PS2_FAKE_SHIFT = 8'h12;

    localparam logic [8:0] MOD_LSHIFT = 9'h012;
    localparam logic [8:0] MOD_RSHIFT = 9'h059;
    localparam logic [8:0] MOD_LCTRL  = 9'h014;
    localparam logic [8:0] MOD_RCTRL  = 9'h114;
    localparam logic [8:0] MOD_LALT   = 9'h011;
    localparam logic [8:0] MOD_RALT   = 9'h111;
    localparam logic [8:0] MOD_CAPS   = 9'h058;

    // Keyboard status/ack bytes that never belong to a key sequence.
    function automatic logic is_status(input logic [7:0] b);
        return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hFE) ||
               (b == 8'hEE) || (b == 8'h00) || (b == 8'hFF);
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through event FIFO; a push while full is accepted only
// when a pop frees the head slot in the same cycle.
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int  DEPTH = 8,
    parameter type T     = key_event_t
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     din,
    input  logic pop,
    output T     dout,
    output logic empty,
    output logic full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    T            mem_q [DEPTH];
    logic        do_pop;
    logic        do_push;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

    // Head reads as zero when empty so the event fields idle at a known value.
    always_comb begin
        dout = '0;
        if (!empty) dout = mem_q[rd_ptr_q[AW-1:0]];
    end

endmodule

// File: rtl/ps2_scancode_ctrl.sv
// Turns checked Set-2 scan bytes into key events: prefix decoding, sequence
// timeout, modifier/caps-lock tracking and a valid/ready event FIFO.
module ps2_scancode_ctrl
    import ps2_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int TIMEOUT_US = 2000,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_code_new,
    input  logic [7:0] ps2_code,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_release,
    output logic [3:0] mods,
    output logic       overflow,
    input  logic       ovf_clr
);

    localparam int TIMEOUT_CYCLES = CLK_FREQ / 1000000 * TIMEOUT_US;
    localparam int TW             = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    dec_state_t    state_q, state_d;
    logic [2:0]    pause_cnt_q, pause_cnt_d;
    logic [TW-1:0] timer_q;
    logic          emit;
    key_event_t    ev_d;
    key_event_t    head;
    logic          fifo_empty;
    logic          fifo_full;
    logic          overflow_q;
    logic          lshift_q, rshift_q, lctrl_q, rctrl_q, lalt_q, ralt_q;
    logic          caps_held_q, caps_lock_q;
    logic [8:0]    mod_key;

    // Valid/ready: the head event is transferred on any cycle where
    // ev_valid && ev_ready; head fields hold steady while ev_valid && !ev_ready.
    always_comb begin
        state_d     = state_q;
        pause_cnt_d = pause_cnt_q;
        emit        = 1'b0;
        ev_d        = '0;
        ev_d.code   = ps2_code;
        if (ps2_code_new) begin
            case (state_q)
                IDLE: begin
                    if (ps2_code == PS2_E0) begin
                        state_d = EXT;
                    end else if (ps2_code == PS2_F0) begin
                        state_d = BRK;
                    end else if (ps2_code == PS2_E1) begin
                        state_d     = PAUSE;
                        pause_cnt_d = 3'd7;
                    end else if (!is_status(ps2_code)) begin
                        emit = 1'b1;
                    end
                end
                EXT: begin
                    state_d = IDLE;
                    if (ps2_code == PS2_F0) begin
                        state_d = EXTBRK;
                    end else if (ps2_code != PS2_FAKE_SHIFT && ps2_code != PS2_E0) begin
                        emit     = 1'b1;
                        ev_d.ext = 1'b1;
                    end
                end
                BRK: begin
                    // A prefix after F0 abandons the break and starts over.
                    if (ps2_code == PS2_E0) begin
                        state_d = EXT;
                    end else if (ps2_code == PS2_F0) begin
                        state_d = BRK;
                    end else begin
                        state_d  = IDLE;
                        emit     = 1'b1;
                        ev_d.rel = 1'b1;
                    end
                end
                EXTBRK: begin
                    state_d = IDLE;
                    if (ps2_code != PS2_FAKE_SHIFT) begin
                        emit     = 1'b1;
                        ev_d.ext = 1'b1;
                        ev_d.rel = 1'b1;
                    end
                end
                PAUSE: begin
                    pause_cnt_d = pause_cnt_q - 3'd1;
                    if (pause_cnt_q == 3'd1) begin
                        state_d   = IDLE;
                        emit      = 1'b1;
                        ev_d.ext  = 1'b1;
                        ev_d.code = PS2_E1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pause_cnt_q <= '0;
            timer_q     <= '0;
        end else if (ps2_code_new) begin
            state_q     <= state_d;
            pause_cnt_q <= pause_cnt_d;
            timer_q     <= '0;
        end else if (state_q != IDLE) begin
            if (timer_q == TIMER_LAST) begin
                state_q <= IDLE;
                timer_q <= '0;
            end else begin
                timer_q <= timer_q + TW'(1);
            end
        end
    end

    assign mod_key = {ev_d.ext, ev_d.code};

    // Modifiers follow every emitted event, even one the FIFO drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lshift_q    <= 1'b0;
            rshift_q    <= 1'b0;
            lctrl_q     <= 1'b0;
            rctrl_q     <= 1'b0;
            lalt_q      <= 1'b0;
            ralt_q      <= 1'b0;
            caps_held_q <= 1'b0;
            caps_lock_q <= 1'b0;
        end else if (emit) begin
            case (mod_key)
                MOD_LSHIFT: lshift_q <= !ev_d.rel;
                MOD_RSHIFT: rshift_q <= !ev_d.rel;
                MOD_LCTRL:  lctrl_q  <= !ev_d.rel;
                MOD_RCTRL:  rctrl_q  <= !ev_d.rel;
                MOD_LALT:   lalt_q   <= !ev_d.rel;
                MOD_RALT:   ralt_q   <= !ev_d.rel;
                MOD_CAPS: begin
                    if (!ev_d.rel && !caps_held_q) caps_lock_q <= !caps_lock_q;
                    caps_held_q <= !ev_d.rel;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= (emit && fifo_full && !ev_ready) || (overflow_q && !ovf_clr);
        end
    end

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (key_event_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (emit),
        .din   (ev_d),
        .pop   (ev_ready),
        .dout  (head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign ev_valid   = !fifo_empty;
    assign ev_code    = head.code;
    assign ev_ext     = head.ext;
    assign ev_release = head.rel;
    assign mods       = {caps_lock_q, lalt_q | ralt_q, lctrl_q | rctrl_q, lshift_q | rshift_q};
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_scancode_ctrl.sv
// Bench for ps2_scancode_ctrl: byte-sequence reference model with an event
// queue, per-cycle output compare, directed scenarios and random traffic.
module tb_ps2_scancode_ctrl;

  localparam int CLK_FREQ   = 1000000;
  localparam int TIMEOUT_US = 40;
  localparam int DEPTH      = 8;
  localparam int TCYC       = CLK_FREQ / 1000000 * TIMEOUT_US;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_code_new;
  logic [7:0] ps2_code;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_release;
  logic [3:0] mods;
  logic       overflow;
  logic       ovf_clr;

  ps2_scancode_ctrl #(
    .CLK_FREQ   (CLK_FREQ),
    .TIMEOUT_US (TIMEOUT_US),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ps2_code_new (ps2_code_new),
    .ps2_code     (ps2_code),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_code      (ev_code),
    .ev_ext       (ev_ext),
    .ev_release   (ev_release),
    .mods         (mods),
    .overflow     (overflow),
    .ovf_clr      (ovf_clr)
  );

  // clock
  always #5 clk = ~clk;

  // reference model state: events are {ext, rel, code}
  logic [9:0] exp_q[$];
  logic [7:0] seq_q[$];
  bit         held[512];
  bit         caps_m;
  bit         ovf_m;
  int         idle_cnt;
  bit         cmp_en;
  int         passed;
  int         total;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [3:0] mods_m();
    return {caps_m, held[9'h011] | held[9'h111], held[9'h014] | held[9'h114],
            held[9'h012] | held[9'h059]};
  endfunction

  // Interpret the pending byte sequence as a whole after each new byte.
  task automatic model_byte(input logic [7:0] b, output bit em, output logic [9:0] ev);
    em = 0;
    ev = '0;
    seq_q.push_back(b);
    if (seq_q[0] == 8'hE1) begin
      if (seq_q.size() == 8) begin
        em = 1; ev = {2'b10, 8'hE1}; seq_q.delete();
      end
    end else if (seq_q.size() == 1) begin
      if (b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF}) seq_q.delete();
      else if (b != 8'hE0 && b != 8'hF0) begin
        em = 1; ev = {2'b00, b}; seq_q.delete();
      end
    end else if (seq_q.size() == 2 && seq_q[0] == 8'hE0) begin
      if (b == 8'hF0) begin
      end else if (b == 8'h12 || b == 8'hE0) begin
        seq_q.delete();
      end else begin
        em = 1; ev = {2'b10, b}; seq_q.delete();
      end
    end else if (seq_q.size() == 2) begin
      seq_q.delete();
      if (b == 8'hE0 || b == 8'hF0) seq_q.push_back(b);
      else begin em = 1; ev = {2'b01, b}; end
    end else begin
      seq_q.delete();
      if (b != 8'h12) begin em = 1; ev = {2'b11, b}; end
    end
  endtask

  // model update on each active edge (and immediately on reset)
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        exp_q.delete();
        seq_q.delete();
        for (int i = 0; i < 512; i++) held[i] = 0;
        caps_m = 0;
        ovf_m = 0;
        idle_cnt = 0;
      end else begin
        bit em;
        bit pop;
        bit set_ovf;
        logic [9:0] ev;
        em = 0;
        ev = '0;
        set_ovf = 0;
        pop = ev_ready && (exp_q.size() != 0);
        if (ps2_code_new) begin
          if (idle_cnt >= TCYC) seq_q.delete();
          idle_cnt = 0;
          model_byte(ps2_code, em, ev);
        end else begin
          idle_cnt++;
        end
        if (pop) void'(exp_q.pop_front());
        if (em) begin
          if (exp_q.size() < DEPTH) exp_q.push_back(ev);
          else set_ovf = 1;
          if (ev[9:0] == 10'h058 && !held[9'h058]) caps_m = !caps_m;
          held[{ev[9], ev[7:0]}] = !ev[8];
        end
        ovf_m = set_ovf ? 1'b1 : (ovf_clr ? 1'b0 : ovf_m);
      end
    end
  end

  // scoreboard compare, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("ev_valid", ev_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) check("ev_head", {ev_ext, ev_release, ev_code}, exp_q[0]);
        check("mods", mods, mods_m());
        check("overflow", overflow, ovf_m);
      end
    end
  end

  // driver: apply inputs #1 after an edge, return #1 after the next edge
  task automatic drive(input logic nw, input logic [7:0] b, input logic rdy, input logic clr);
    ps2_code_new = nw;
    ps2_code = b;
    ev_ready = rdy;
    ovf_clr = clr;
    @(posedge clk);
    #1;
    ps2_code_new = 1'b0;
    ovf_clr = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    drive(1'b1, b, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 100) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      g++;
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check("drain_empty", ev_valid, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    ps2_code_new = 1'b0;
    ps2_code = 8'h00;
    ev_ready = 1'b0;
    ovf_clr = 1'b0;
    cmp_en = 1'b0;
    passed = 0;
    total = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", ev_valid, 1'b0);
    check("rst_event", {ev_ext, ev_release, ev_code}, 10'h000);
    check("rst_mods", mods, 4'h0);
    check("rst_overflow", overflow, 1'b0);
    rst = 1'b0;
    cmp_en = 1'b1;
    @(posedge clk);
    #1;

    // plain make, visible the cycle after the byte
    check("pre_valid", ev_valid, 1'b0);
    send(8'h1C);
    check("make_valid", ev_valid, 1'b1);
    check("make_head", {ev_ext, ev_release, ev_code}, 10'h01C);
    check("make_mods", mods, 4'h0);
    drain();

    send(8'hF0); send(8'h1C);
    check("break_head", {ev_ext, ev_release, ev_code}, 10'h11C);
    drain();

    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    check("ext_make", {ev_ext, ev_release, ev_code}, 10'h275);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check("ext_break", {ev_ext, ev_release, ev_code}, 10'h375);
    drain();

    send(8'hE0); send(8'h12); send(8'hE0); send(8'h7C);
    check("prtsc_count", exp_q.size(), 1);
    check("prtsc_head", {ev_ext, ev_release, ev_code}, 10'h27C);
    drain();

    send(8'h12);
    check("shift_on", mods, 4'h1);
    send(8'h1C); send(8'hF0); send(8'h12);
    check("shift_off", mods, 4'h0);
    drain();

    send(8'h58);
    check("caps_1", mods, 4'h8);
    send(8'h58);
    check("caps_repeat", mods, 4'h8);
    send(8'hF0); send(8'h58);
    check("caps_break", mods, 4'h8);
    send(8'h58);
    check("caps_2", mods, 4'h0);
    drain();

    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    check("pause_count", exp_q.size(), 1);
    check("pause_head", {ev_ext, ev_release, ev_code}, 10'h2E1);
    drain();

    send(8'hAA); send(8'hFA); idle(2);
    check("status_none", ev_valid, 1'b0);

    send(8'hE0); idle(3 * TCYC); send(8'h1C);
    check("timeout_head", {ev_ext, ev_release, ev_code}, 10'h01C);
    drain();

    send(8'hE0); idle(TCYC / 2); send(8'h75);
    check("gap_ok_head", {ev_ext, ev_release, ev_code}, 10'h275);
    drain();

    // overflow with a stalled consumer
    for (int i = 0; i <= DEPTH; i++) send(8'h20 + 8'(i));
    check("ovf_set", overflow, 1'b1);
    check("ovf_head", {ev_ext, ev_release, ev_code}, 10'h020);
    check("ovf_count", exp_q.size(), DEPTH);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    check("ovf_clr", overflow, 1'b0);
    drive(1'b1, 8'h40, 1'b1, 1'b0);
    check("full_pushpop_ovf", overflow, 1'b0);
    check("full_pushpop_head", {ev_ext, ev_release, ev_code}, 10'h021);
    drain();

    // reset in the middle of a sequence with events pending
    send(8'h12); send(8'hE0);
    rst = 1'b1;
    #1;
    check("midrst_valid", ev_valid, 1'b0);
    check("midrst_mods", mods, 4'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(8'h1C);
    check("postrst_head", {ev_ext, ev_release, ev_code}, 10'h01C);
    drain();

    // randomized traffic
    for (int n = 0; n < 700; n++) begin
      int gap;
      int pick;
      logic [7:0] b;
      logic [7:0] tbl [14];
      tbl = '{8'h12, 8'h59, 8'h14, 8'h11, 8'h58, 8'h1C, 8'h75,
              8'h7C, 8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'hE1, 8'hAA};
      gap = ($urandom_range(0, 59) == 0) ? TCYC + 10 : $urandom_range(0, 5);
      for (int g = 0; g < gap; g++)
        drive(1'b0, 8'h00, ((n / 60) % 2 == 0) ? 1'b1 : ($urandom_range(0, 3) == 0),
              $urandom_range(0, 49) == 0);
      pick = $urandom_range(0, 15);
      b = (pick < 14) ? tbl[pick] : 8'($urandom_range(0, 255));
      drive(1'b1, b, ((n / 60) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0),
            1'b0);
    end
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
